// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR access controller:
// Zicsr funct3 codes, implemented CSR numbers and controller state encoding.
package csr_pkg;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;
    localparam logic [11:0] CSR_MIMPID     = 12'hF13;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;

    // csr[11:10] value marking a read-only CSR
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_WRITE,
        ST_RESP
    } state_e;

    function automatic logic is_implemented_csr(input logic [11:0] csr);
        case (csr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MCOUNTEREN,
            CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
            CSR_MCYCLEH, CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID, CSR_MHARTID: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_wdata_calc.sv
// New CSR value for the read-modify-write: replace, set bits or clear bits,
// selected by funct3[1:0] (shared by register and immediate forms).
module csr_wdata_calc
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] new_o
);

    // NOTE: combinational logic uses blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        new_o = operand_i;
        case (op_i)
            F3_RS[1:0]: new_o = old_i | operand_i;
            F3_RC[1:0]: new_o = old_i & ~operand_i;
            default:    new_o = operand_i;
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Initiator side of the machine-mode CSR file port: runs one Zicsr
// read-modify-write per request and returns the old value for rd.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [11:0]       req_csr_i,
    input  logic [4:0]        req_rs1_idx_i,
    input  logic [XLEN-1:0]   req_rs1_data_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_illegal_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic              csr_en_read_o,
    output logic              csr_en_write_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    input  logic [XLEN-1:0]   csr_rdata_i
);

    state_e            state_q;
    logic [1:0]        op_q;
    logic              write_req_q;
    logic [XLEN-1:0]   operand_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic              resp_valid_q;
    logic              resp_illegal_q;
    logic [CSR_AW-1:0] csr_addr_q;
    logic              csr_en_read_q;
    logic              csr_en_write_q;
    logic [XLEN-1:0]   csr_wdata_q;

    logic [XLEN-1:0]   operand_d;
    logic              write_req_d;
    logic              legal_d;
    logic [XLEN-1:0]   new_val;

    // Set/clear with a zero source never writes, so those may target read-only CSRs.
    always_comb begin
        operand_d   = req_funct3_i[2] ? XLEN'(req_rs1_idx_i) : req_rs1_data_i;
        write_req_d = (req_funct3_i == F3_RW) || (req_funct3_i == F3_RWI)
                      || (req_rs1_idx_i != 5'd0);
        legal_d     = (req_funct3_i inside {F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI})
                      && is_implemented_csr(req_csr_i)
                      && !(write_req_d && (req_csr_i[11:10] == CSR_RO_FIELD));
    end

    csr_wdata_calc #(.XLEN(XLEN)) u_wdata_calc (
        .op_i      (op_q),
        .old_i     (csr_rdata_i),
        .operand_i (operand_q),
        .new_o     (new_val)
    );

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            op_q           <= 2'b00;
            write_req_q    <= 1'b0;
            operand_q      <= '0;
            resp_rdata_q   <= '0;
            resp_valid_q   <= 1'b0;
            resp_illegal_q <= 1'b0;
            csr_addr_q     <= '0;
            csr_en_read_q  <= 1'b0;
            csr_en_write_q <= 1'b0;
            csr_wdata_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        op_q        <= req_funct3_i[1:0];
                        operand_q   <= operand_d;
                        write_req_q <= write_req_d;
                        if (legal_d) begin
                            csr_addr_q    <= CSR_AW'(req_csr_i);
                            csr_en_read_q <= 1'b1;
                            state_q       <= ST_READ;
                        end else begin
                            resp_rdata_q   <= '0;
                            resp_illegal_q <= 1'b1;
                            resp_valid_q   <= 1'b1;
                            state_q        <= ST_RESP;
                        end
                    end
                end
                ST_READ: begin
                    csr_en_read_q <= 1'b0;
                    state_q       <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // CSR file data_out is valid in this cycle, one after the read enable.
                    resp_rdata_q <= csr_rdata_i;
                    if (write_req_q) begin
                        csr_en_write_q <= 1'b1;
                        csr_wdata_q    <= new_val;
                    end
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    csr_en_write_q <= 1'b0;
                    resp_valid_q   <= 1'b1;
                    state_q        <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q   <= 1'b0;
                        resp_illegal_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o    = (state_q == ST_IDLE);
    assign resp_valid_o   = resp_valid_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_illegal_o = resp_illegal_q;
    assign csr_addr_o     = csr_addr_q;
    assign csr_en_read_o  = csr_en_read_q;
    assign csr_en_write_o = csr_en_write_q;
    assign csr_wdata_o    = csr_wdata_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed scenarios plus random
// requests against a behavioural CSR model and a registered CSR file model.
module tb_csr_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o;
    logic [2:0]  req_funct3_i;
    logic [11:0] req_csr_i;
    logic [4:0]  req_rs1_idx_i;
    logic [31:0] req_rs1_data_i;
    logic        resp_valid_o, resp_ready_i, resp_illegal_o;
    logic [31:0] resp_rdata_o;
    logic [31:0] csr_addr_o;
    logic        csr_en_read_o, csr_en_write_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_rdata_i = 32'h0;

    csr_access_ctrl #(.XLEN(32), .CSR_AW(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_csr_i(req_csr_i),
        .req_rs1_idx_i(req_rs1_idx_i), .req_rs1_data_i(req_rs1_data_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_illegal_o(resp_illegal_o),
        .csr_addr_o(csr_addr_o), .csr_en_read_o(csr_en_read_o),
        .csr_en_write_o(csr_en_write_o), .csr_wdata_o(csr_wdata_o),
        .csr_rdata_i(csr_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // CSR file model: registered read data, with a side door for preloading.
    bit [31:0]   mem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [31:0] pre_data = 32'h0;
    int          cyc = 0;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (pre_en) mem[pre_addr] <= pre_data;
        if (csr_en_write_o) mem[csr_addr_o[11:0]] <= csr_wdata_o;
        if (csr_en_read_o) csr_rdata_i <= mem[csr_addr_o[11:0]];
    end

    // Enable-pulse monitor
    int          rd_pulses = 0, wr_pulses = 0, both_hi = 0, long_pulse = 0;
    int          last_rd_cyc = 0, last_wr_cyc = 0;
    logic [11:0] last_wr_addr = 12'h0;
    logic [31:0] last_wr_data = 32'h0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;

    always @(negedge clk_i) begin
        if (csr_en_read_o && csr_en_write_o) both_hi <= both_hi + 1;
        if (csr_en_read_o) begin
            rd_pulses   <= rd_pulses + 1;
            last_rd_cyc <= cyc;
            if (prev_rd) long_pulse <= long_pulse + 1;
        end
        if (csr_en_write_o) begin
            wr_pulses    <= wr_pulses + 1;
            last_wr_cyc  <= cyc;
            last_wr_addr <= csr_addr_o[11:0];
            last_wr_data <= csr_wdata_o;
            if (prev_wr) long_pulse <= long_pulse + 1;
        end
        prev_rd <= csr_en_read_o;
        prev_wr <= csr_en_write_o;
    end

    // Reference model: architectural CSR contents and Zicsr rules.
    bit [31:0] ref_csr [0:4095];

    function automatic void ref_step(input logic [2:0] f3, input logic [11:0] csr,
                                     input logic [4:0] idx, input logic [31:0] d,
                                     output logic [31:0] rdata, output logic ill,
                                     output logic wr, output logic [31:0] wdata);
        logic [31:0] opnd;
        logic [31:0] old;
        logic [31:0] nv;
        bit          implemented;
        bit          wants_write;
        opnd        = f3[2] ? {27'd0, idx} : d;
        implemented = csr inside {12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h342,
                                  12'h300, 12'h305, 12'h341, 12'h344, 12'h304, 12'hB00,
                                  12'hB80, 12'hB02, 12'hB82, 12'h306};
        wants_write = (f3 == 3'b001) || (f3 == 3'b101) || (idx != 5'd0);
        ill = (f3 == 3'b000) || (f3 == 3'b100) || !implemented
              || (wants_write && csr >= 12'hC00);
        rdata = 32'h0; wr = 1'b0; wdata = 32'h0;
        if (!ill) begin
            old = ref_csr[csr];
            if (f3 == 3'b001 || f3 == 3'b101)      nv = opnd;
            else if (f3 == 3'b010 || f3 == 3'b110) nv = old | opnd;
            else                                   nv = old & ~opnd;
            rdata = old;
            wr    = wants_write;
            if (wr) begin
                ref_csr[csr] = nv;
                wdata = nv;
            end
        end
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        int          lat;
        int          rd_n;
        int          wr_n;
        int          wr_gap;
        logic [11:0] wr_addr;
        logic [31:0] wr_data;
        int          hold_bad;
    } obs_t;

    // Drives one request from a negedge with the controller idle and returns what was seen.
    task automatic issue(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] idx,
                         input logic [31:0] d, input int hold, input bit poke, output obs_t o);
        int rd0, wr0;
        rd0 = rd_pulses; wr0 = wr_pulses;
        o = '{default: 0};
        req_valid_i = 1'b1; req_funct3_i = f3; req_csr_i = csr;
        req_rs1_idx_i = idx; req_rs1_data_i = d;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        o.lat = 1;
        while (!resp_valid_o && o.lat < 20) begin
            @(negedge clk_i);
            o.lat++;
        end
        for (int i = 0; i < hold; i++) begin
            if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0) o.hold_bad++;
            req_valid_i = poke && (i == 1);
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        o.rdata = resp_rdata_o;
        o.illegal = resp_illegal_o;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        o.rd_n = rd_pulses - rd0;
        o.wr_n = wr_pulses - wr0;
        o.wr_addr = last_wr_addr;
        o.wr_data = last_wr_data;
        o.wr_gap = (o.rd_n > 0 && o.wr_n > 0) ? last_wr_cyc - last_rd_cyc : -1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk_i);
        pre_en = 1'b0;
        ref_csr[a] = d;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #2;
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", req_ready_o); end
        n_tests++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid_o); end
        n_tests++; if (resp_illegal_o !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got %b exp 0", resp_illegal_o); end
        n_tests++; if (csr_en_read_o !== 1'b0 || csr_en_write_o !== 1'b0) begin n_fail++; $display("FAIL rst_enables got rd=%b wr=%b exp 0/0", csr_en_read_o, csr_en_write_o); end
        n_tests++; if (resp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", resp_rdata_o); end
        n_tests++; if (csr_addr_o !== 32'h0 || csr_wdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr_wdata got %h/%h exp 0/0", csr_addr_o, csr_wdata_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_rw_mtvec();
        obs_t o;
        logic [31:0] er, ew; logic ei, ewr;
        ref_step(3'b001, 12'h305, 5'd7, 32'h0000_1000, er, ei, ewr, ew);
        issue(3'b001, 12'h305, 5'd7, 32'h0000_1000, 0, 1'b0, o);
        n_tests++; if (o.lat !== 4) begin n_fail++; $display("FAIL rw1_latency got %0d exp 4", o.lat); end
        n_tests++; if (o.rdata !== 32'h0 || o.illegal !== 1'b0) begin n_fail++; $display("FAIL rw1_resp got %h ill=%b exp 0 ill=0", o.rdata, o.illegal); end
        n_tests++; if (o.rd_n !== 1 || o.wr_n !== 1) begin n_fail++; $display("FAIL rw1_pulses got rd=%0d wr=%0d exp 1/1", o.rd_n, o.wr_n); end
        n_tests++; if (o.wr_addr !== 12'h305 || o.wr_data !== 32'h1000) begin n_fail++; $display("FAIL rw1_write got %h<=%h exp 305<=1000", o.wr_addr, o.wr_data); end
        n_tests++; if (o.wr_gap !== 2) begin n_fail++; $display("FAIL rw1_rd_to_wr got %0d cycles exp 2", o.wr_gap); end
        ref_step(3'b001, 12'h305, 5'd7, 32'h0000_2000, er, ei, ewr, ew);
        issue(3'b001, 12'h305, 5'd7, 32'h0000_2000, 0, 1'b0, o);
        n_tests++; if (o.rdata !== 32'h1000) begin n_fail++; $display("FAIL rw2_rdata got %h exp 1000", o.rdata); end
    endtask

    task automatic test_rs_rc_mstatus();
        obs_t o;
        logic [31:0] er, ew; logic ei, ewr;
        preload(12'h300, 32'h8);
        ref_step(3'b010, 12'h300, 5'd5, 32'h80, er, ei, ewr, ew);
        issue(3'b010, 12'h300, 5'd5, 32'h80, 0, 1'b0, o);
        n_tests++; if (o.rdata !== 32'h8 || o.wr_data !== 32'h88 || o.wr_n !== 1) begin n_fail++; $display("FAIL rs_mstatus got rdata=%h wdata=%h wr=%0d exp 8/88/1", o.rdata, o.wr_data, o.wr_n); end
        ref_step(3'b011, 12'h300, 5'd6, 32'h8, er, ei, ewr, ew);
        issue(3'b011, 12'h300, 5'd6, 32'h8, 0, 1'b0, o);
        n_tests++; if (o.rdata !== 32'h88 || o.wr_data !== 32'h80 || o.wr_n !== 1) begin n_fail++; $display("FAIL rc_mstatus got rdata=%h wdata=%h wr=%0d exp 88/80/1", o.rdata, o.wr_data, o.wr_n); end
    endtask

    task automatic test_readonly();
        obs_t o;
        logic [31:0] er, ew; logic ei, ewr;
        preload(12'hF11, 32'h0000_0489);
        ref_step(3'b010, 12'hF11, 5'd0, 32'hFFFF_FFFF, er, ei, ewr, ew);
        issue(3'b010, 12'hF11, 5'd0, 32'hFFFF_FFFF, 0, 1'b0, o);
        n_tests++; if (o.illegal !== 1'b0 || o.rdata !== 32'h489 || o.lat !== 4) begin n_fail++; $display("FAIL ro_read got ill=%b rdata=%h lat=%0d exp 0/489/4", o.illegal, o.rdata, o.lat); end
        n_tests++; if (o.rd_n !== 1 || o.wr_n !== 0) begin n_fail++; $display("FAIL ro_read_pulses got rd=%0d wr=%0d exp 1/0", o.rd_n, o.wr_n); end
        ref_step(3'b001, 12'hF11, 5'd3, 32'h1234, er, ei, ewr, ew);
        issue(3'b001, 12'hF11, 5'd3, 32'h1234, 0, 1'b0, o);
        n_tests++; if (o.illegal !== 1'b1 || o.lat !== 1) begin n_fail++; $display("FAIL ro_write got ill=%b lat=%0d exp 1/1", o.illegal, o.lat); end
        n_tests++; if (o.rd_n !== 0 || o.wr_n !== 0) begin n_fail++; $display("FAIL ro_write_pulses got rd=%0d wr=%0d exp 0/0", o.rd_n, o.wr_n); end
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [31:0] er, ew; logic ei, ewr;
        ref_step(3'b001, 12'h7C0, 5'd1, 32'h55, er, ei, ewr, ew);
        issue(3'b001, 12'h7C0, 5'd1, 32'h55, 0, 1'b0, o);
        n_tests++; if (o.illegal !== 1'b1 || o.rdata !== 32'h0 || o.rd_n !== 0 || o.wr_n !== 0) begin n_fail++; $display("FAIL ill_csr got ill=%b rdata=%h rd=%0d wr=%0d exp 1/0/0/0", o.illegal, o.rdata, o.rd_n, o.wr_n); end
        ref_step(3'b100, 12'h300, 5'd1, 32'h55, er, ei, ewr, ew);
        issue(3'b100, 12'h300, 5'd1, 32'h55, 0, 1'b0, o);
        n_tests++; if (o.illegal !== 1'b1 || o.rdata !== 32'h0 || o.rd_n !== 0 || o.wr_n !== 0) begin n_fail++; $display("FAIL ill_f3_100 got ill=%b rdata=%h rd=%0d wr=%0d exp 1/0/0/0", o.illegal, o.rdata, o.rd_n, o.wr_n); end
        ref_step(3'b000, 12'h305, 5'd0, 32'h0, er, ei, ewr, ew);
        issue(3'b000, 12'h305, 5'd0, 32'h0, 0, 1'b0, o);
        n_tests++; if (o.illegal !== 1'b1 || o.lat !== 1) begin n_fail++; $display("FAIL ill_f3_000 got ill=%b lat=%0d exp 1/1", o.illegal, o.lat); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [31:0] er, ew; logic ei, ewr;
        ref_step(3'b101, 12'h341, 5'h1F, 32'hDEAD_BEEF, er, ei, ewr, ew);
        issue(3'b101, 12'h341, 5'h1F, 32'hDEAD_BEEF, 5, 1'b1, o);
        n_tests++; if (o.hold_bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0", o.hold_bad); end
        n_tests++; if (o.wr_data !== 32'h1F || o.wr_addr !== 12'h341) begin n_fail++; $display("FAIL bp_write got %h<=%h exp 341<=1f", o.wr_addr, o.wr_data); end
        n_tests++; if (o.rd_n !== 1 || o.wr_n !== 1) begin n_fail++; $display("FAIL bp_poke_ignored got rd=%0d wr=%0d exp 1/1", o.rd_n, o.wr_n); end
        n_tests++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_after got ready=%b valid=%b exp 1/0", req_ready_o, resp_valid_o); end
    endtask

    task automatic test_reset_midflight();
        obs_t o;
        logic [31:0] er, ew; logic ei, ewr;
        req_valid_i = 1'b1; req_funct3_i = 3'b001; req_csr_i = 12'h304;
        req_rs1_idx_i = 5'd3; req_rs1_data_i = 32'hABCD;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        n_tests++; if (csr_en_read_o !== 1'b1) begin n_fail++; $display("FAIL mid_read_entry got en_read=%b exp 1", csr_en_read_o); end
        #1 rst_i = 1'b1;
        #1;
        n_tests++; if (csr_en_read_o !== 1'b0 || req_ready_o !== 1'b1 || csr_addr_o !== 32'h0) begin n_fail++; $display("FAIL mid_read_reset got rd=%b ready=%b addr=%h exp 0/1/0", csr_en_read_o, req_ready_o, csr_addr_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        req_valid_i = 1'b1; req_rs1_data_i = 32'h5555;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        n_tests++; if (csr_en_write_o !== 1'b1) begin n_fail++; $display("FAIL mid_write_entry got en_write=%b exp 1", csr_en_write_o); end
        #1 rst_i = 1'b1;
        #1;
        n_tests++; if (csr_en_write_o !== 1'b0 || csr_wdata_o !== 32'h0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_write_reset got wr=%b wdata=%h valid=%b ready=%b exp 0/0/0/1", csr_en_write_o, csr_wdata_o, resp_valid_o, req_ready_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        ref_step(3'b001, 12'h304, 5'd2, 32'h77, er, ei, ewr, ew);
        issue(3'b001, 12'h304, 5'd2, 32'h77, 0, 1'b0, o);
        n_tests++; if (o.rdata !== er || o.illegal !== 1'b0 || o.lat !== 4 || o.wr_data !== 32'h77) begin n_fail++; $display("FAIL mid_recover got rdata=%h ill=%b lat=%0d wdata=%h exp %h/0/4/77", o.rdata, o.illegal, o.lat, o.wr_data, er); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] er, ew; logic ei, ewr;
        logic [11:0] impl_list [16];
        logic [2:0]  f3;
        logic [11:0] csr;
        logic [4:0]  idx;
        logic [31:0] d;
        impl_list = '{12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h342, 12'h300, 12'h305,
                      12'h341, 12'h344, 12'h304, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h306};
        for (int n = 0; n < 60; n++) begin
            f3  = 3'($urandom_range(0, 7));
            csr = ($urandom_range(0, 4) == 0) ? 12'($urandom) : impl_list[$urandom_range(0, 15)];
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            d   = $urandom;
            ref_step(f3, csr, idx, d, er, ei, ewr, ew);
            issue(f3, csr, idx, d, $urandom_range(0, 2), 1'b0, o);
            n_tests++;
            if (o.illegal !== ei || o.rdata !== er || o.lat !== (ei ? 1 : 4)
                || o.rd_n !== (ei ? 0 : 1) || o.wr_n !== (ewr ? 1 : 0)
                || (ewr && (o.wr_data !== ew || o.wr_addr !== csr))) begin
                n_fail++;
                $display("FAIL rand%0d f3=%b csr=%h idx=%0d got ill=%b rdata=%h lat=%0d rd=%0d wr=%0d wdata=%h exp ill=%b rdata=%h wr=%b wdata=%h",
                         n, f3, csr, idx, o.illegal, o.rdata, o.lat, o.rd_n, o.wr_n, o.wr_data, ei, er, ewr, ew);
            end
        end
    endtask

    task automatic test_enable_rules();
        n_tests++; if (both_hi !== 0) begin n_fail++; $display("FAIL en_exclusive got %0d overlap cycles exp 0", both_hi); end
        n_tests++; if (long_pulse !== 0) begin n_fail++; $display("FAIL en_single_cycle got %0d extended pulses exp 0", long_pulse); end
    endtask

    initial begin
        req_valid_i = 1'b0; resp_ready_i = 1'b0;
        req_funct3_i = 3'b0; req_csr_i = 12'h0; req_rs1_idx_i = 5'd0; req_rs1_data_i = 32'h0;
        test_reset();
        test_rw_mtvec();
        test_rs_rc_mstatus();
        test_readonly();
        test_illegal();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_enable_rules();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
